interrupt_priority_logic: RTL and testbench

Clocked request-side datapath of the 8259 PIC: captures the eight IR lines into the Interrupt Request Register (IRR) and applies the interrupt mask. A rotating priority resolver compares pending requests against the In-Service Register (ISR). The block sits directly upstream of Control_Unit. It drives Control_Unit's INTERNAL_INT and IR_NUM and consumes its interrupt_mask, LEVEL, R and AEOI outputs, plus the processor's INTA_ strobe.

---
 rtl/pic_pkg.sv | 21 ++
 rtl/rot_priority_enc.sv | 28 ++
 rtl/interrupt_priority_logic.sv | 154 +++++++++++++++
 tb/tb_interrupt_priority_logic.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 request-side priority logic.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam int LVL_W  = 3;

  localparam logic [LVL_W-1:0] LP_RESET     = 3'd7;
  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    ACK1 = 1'b1
  } pic_state_e;

  // Rank 0 is the highest priority; the level just after lp ranks first.
  function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] lvl,
                                                 input logic [LVL_W-1:0] lp);
    return lvl - lp - 3'd1;
  endfunction

endpackage

// File: rtl/rot_priority_enc.sv
// Rotating priority encoder: picks the first set bit starting at LP+1, modulo NUM_IR.
module rot_priority_enc #(
  parameter int NUM_IR = 8,
  parameter int LVL_W  = $clog2(NUM_IR)
) (
  input  logic [NUM_IR-1:0] vector,
  input  logic [LVL_W-1:0]  LP,
  output logic              valid,
  output logic [LVL_W-1:0]  level
);

  int idx;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    valid = 1'b0;
    level = '0;
    idx   = 0;
    for (int i = NUM_IR; i >= 1; i--) begin
      idx = (int'(LP) + i) % NUM_IR;
      if (vector[idx]) begin
        valid = 1'b1;
        level = LVL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/interrupt_priority_logic.sv
// 8259 IRR capture, masking, rotating priority resolution and ISR tracking.
// Define PIC_SPECIFIC_EOI_EN to add the specific-EOI ports SEOI / SEOI_LEVEL.
module interrupt_priority_logic
  import pic_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IR,
  input  logic [7:0] interrupt_mask,
  input  logic       LEVEL,
  input  logic       R,
  input  logic       AEOI,
  input  logic       EOI,
`ifdef PIC_SPECIFIC_EOI_EN
  input  logic       SEOI,
  input  logic [2:0] SEOI_LEVEL,
`endif
  input  logic       INTA_,
  output logic       INTERNAL_INT,
  output logic [2:0] IR_NUM,
  output logic [7:0] IRR_OUT,
  output logic [7:0] ISR_OUT
);

  pic_state_e state_q, state_d;
  logic [7:0] ir_hist_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] ack_clr;
  logic [2:0] lp_q, lp_d;
  logic [2:0] irnum_q, irnum_d;
  logic       spur_q, spur_d;
  logic       int_q, int_d;
  logic       inta_s1_q, inta_s2_q, inta_prev_q;
  logic       inta_fall;

  logic       cand_valid, isr_valid, req;
  logic [2:0] cand_lvl, isr_lvl;

  rot_priority_enc #(.NUM_IR(NUM_IR)) u_req_enc (
    .vector (irr_q & ~interrupt_mask),
    .LP     (lp_q),
    .valid  (cand_valid),
    .level  (cand_lvl)
  );

  rot_priority_enc #(.NUM_IR(NUM_IR)) u_isr_enc (
    .vector (isr_q),
    .LP     (lp_q),
    .valid  (isr_valid),
    .level  (isr_lvl)
  );

  assign inta_fall = inta_prev_q & ~inta_s2_q;
  assign req = cand_valid &&
               (!isr_valid || (prio_rank(cand_lvl, lp_q) < prio_rank(isr_lvl, lp_q)));

  always_comb begin
    state_d = state_q;
    isr_d   = isr_q;
    lp_d    = lp_q;
    irnum_d = irnum_q;
    spur_d  = spur_q;
    int_d   = int_q;
    ack_clr = '0;

    // End-of-interrupt acts on the pre-acknowledge ISR; the acknowledge below may then set a bit.
`ifdef PIC_SPECIFIC_EOI_EN
    if (SEOI) begin
      isr_d[SEOI_LEVEL] = 1'b0;
      if (R) lp_d = SEOI_LEVEL;
    end else if (EOI && isr_valid) begin
      isr_d[isr_lvl] = 1'b0;
      if (R) lp_d = isr_lvl;
    end
`else
    if (EOI && isr_valid) begin
      isr_d[isr_lvl] = 1'b0;
      if (R) lp_d = isr_lvl;
    end
`endif

    case (state_q)
      IDLE: begin
        int_d = req;
        if (inta_fall) begin
          state_d = ACK1;
          int_d   = 1'b1;
          if (req) begin
            irnum_d = cand_lvl;
            spur_d  = 1'b0;
          end else begin
            irnum_d = SPURIOUS_LVL;
            spur_d  = 1'b1;
          end
        end
      end
      ACK1: begin
        int_d = 1'b1;
        if (inta_fall) begin
          state_d = IDLE;
          int_d   = 1'b0;
          if (!spur_q) begin
            ack_clr[irnum_q] = 1'b1;
            if (AEOI) begin
              if (R) lp_d = irnum_q;
            end else begin
              isr_d[irnum_q] = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the same bit outranks the acknowledge clear.
    if (LEVEL) irr_d = IR & ~ack_clr;
    else       irr_d = (irr_q & ~ack_clr) | (IR & ~ir_hist_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      ir_hist_q   <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      lp_q        <= LP_RESET;
      irnum_q     <= '0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      inta_s1_q   <= 1'b1;
      inta_s2_q   <= 1'b1;
      inta_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ir_hist_q   <= IR;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      lp_q        <= lp_d;
      irnum_q     <= irnum_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      inta_s1_q   <= INTA_;
      inta_s2_q   <= inta_s1_q;
      inta_prev_q <= inta_s2_q;
    end
  end

  assign INTERNAL_INT = int_q;
  assign IR_NUM       = irnum_q;
  assign IRR_OUT      = irr_q;
  assign ISR_OUT      = isr_q;

endmodule

// File: tb/tb_interrupt_priority_logic.sv
// Scoreboard bench for interrupt_priority_logic: directed vectors push expectations, a monitor checks them.
module tb_interrupt_priority_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir;
  logic [7:0] mask;
  logic       level, rot, aeoi, eoi, inta;
  logic       intOut;
  logic [2:0] irNum;
  logic [7:0] irrOut, isrOut;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  localparam int SEL_INT = 0;
  localparam int SEL_NUM = 1;
  localparam int SEL_IRR = 2;
  localparam int SEL_ISR = 3;

  interrupt_priority_logic dut (
    .CLK            (clk),
    .RESET          (reset),
    .IR             (ir),
    .interrupt_mask (mask),
    .LEVEL          (level),
    .R              (rot),
    .AEOI           (aeoi),
    .EOI            (eoi),
`ifdef PIC_SPECIFIC_EOI_EN
    .SEOI           (1'b0),
    .SEOI_LEVEL     (3'd0),
`endif
    .INTA_          (inta),
    .INTERNAL_INT   (intOut),
    .IR_NUM         (irNum),
    .IRR_OUT        (irrOut),
    .ISR_OUT        (isrOut)
  );

  always #5 clk = ~clk;

  // Expected values describe the DUT state after the most recent rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectOut(input string name, input int sel, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = val;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] irV, input logic [7:0] maskV,
                               input logic levelV, input logic rotV, input logic aeoiV);
    ir    = irV;
    mask  = maskV;
    level = levelV;
    rot   = rotV;
    aeoi  = aeoiV;
  endtask

  task automatic intaFall();
    inta = 1'b0;
    tick(3);
  endtask

  task automatic intaRise();
    inta = 1'b1;
    tick(3);
  endtask

  task automatic eoiPulse();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    case (e.sel)
      SEL_INT: act = {7'd0, intOut};
      SEL_NUM: act = {5'd0, irNum};
      SEL_IRR: act = irrOut;
      default: act = isrOut;
    endcase
    compared++;
    if (act !== e.exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", e.name, act, e.exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    inta  = 1'b1;
    eoi   = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(2);
    expectOut("reset_int", SEL_INT, 8'h00);
    expectOut("reset_num", SEL_NUM, 8'h00);
    expectOut("reset_irr", SEL_IRR, 8'h00);
    expectOut("reset_isr", SEL_ISR, 8'h00);
    tick(1);
    reset = 1'b0;
    tick(1);

    // Edge mode, single request on IR3
    applyStimulus(8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1);
    expectOut("t1_irr_set", SEL_IRR, 8'h08);
    expectOut("t1_int_1cyc", SEL_INT, 8'h00);
    tick(1);
    expectOut("t1_int_2cyc", SEL_INT, 8'h01);
    intaFall();
    expectOut("t1_num", SEL_NUM, 8'h03);
    intaRise();
    inta = 1'b0;
    tick(2);
    expectOut("t1_int_held", SEL_INT, 8'h01);
    expectOut("t1_isr_early", SEL_ISR, 8'h00);
    tick(1);
    expectOut("t1_int_drop", SEL_INT, 8'h00);
    expectOut("t1_isr", SEL_ISR, 8'h08);
    expectOut("t1_irr", SEL_IRR, 8'h00);
    intaRise();
    ir = 8'h00;
    eoiPulse();
    expectOut("t1_eoi_isr", SEL_ISR, 8'h00);
    tick(2);

    // IR5 and IR2 together, fully nested
    ir = 8'h24;
    tick(2);
    expectOut("t2_int", SEL_INT, 8'h01);
    intaFall();
    expectOut("t2_num_first", SEL_NUM, 8'h02);
    intaRise();
    intaFall();
    expectOut("t2_isr", SEL_ISR, 8'h04);
    expectOut("t2_irr", SEL_IRR, 8'h20);
    intaRise();
    expectOut("t2_int_blocked", SEL_INT, 8'h00);
    eoiPulse();
    expectOut("t2_eoi_isr", SEL_ISR, 8'h00);
    tick(1);
    expectOut("t2_int_after_eoi", SEL_INT, 8'h01);
    intaFall();
    expectOut("t2_num_second", SEL_NUM, 8'h05);
    intaRise();
    intaFall();
    expectOut("t2_isr5", SEL_ISR, 8'h20);
    expectOut("t2_irr_empty", SEL_IRR, 8'h00);
    intaRise();
    ir = 8'h00;
    eoiPulse();
    tick(2);

    // Masked request, then unmask
    applyStimulus(8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
    tick(1);
    expectOut("t3_irr", SEL_IRR, 8'h10);
    tick(3);
    expectOut("t3_int_masked", SEL_INT, 8'h00);
    mask = 8'h00;
    tick(1);
    expectOut("t3_int_unmasked", SEL_INT, 8'h01);
    intaFall();
    intaRise();
    intaFall();
    expectOut("t3_isr", SEL_ISR, 8'h10);
    intaRise();
    ir = 8'h00;
    eoiPulse();
    tick(2);

    // Rotation with automatic EOI
    applyStimulus(8'h02, 8'h00, 1'b0, 1'b1, 1'b1);
    tick(2);
    expectOut("t4_int", SEL_INT, 8'h01);
    intaFall();
    expectOut("t4_num1", SEL_NUM, 8'h01);
    intaRise();
    intaFall();
    expectOut("t4_isr_aeoi", SEL_ISR, 8'h00);
    expectOut("t4_irr_clear", SEL_IRR, 8'h00);
    intaRise();
    ir = 8'h00;
    tick(1);
    ir = 8'h05;
    tick(1);
    expectOut("t4_irr_two", SEL_IRR, 8'h05);
    tick(1);
    intaFall();
    expectOut("t4_num_rot", SEL_NUM, 8'h02);
    intaRise();
    intaFall();
    expectOut("t4_irr_left", SEL_IRR, 8'h01);
    intaRise();
    intaFall();
    expectOut("t4_num0", SEL_NUM, 8'h00);
    intaRise();
    intaFall();
    intaRise();
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick(2);

    // Level mode, request withdrawn before acknowledge
    ir = 8'h40;
    tick(1);
    expectOut("t5_irr_lvl", SEL_IRR, 8'h40);
    tick(1);
    expectOut("t5_int", SEL_INT, 8'h01);
    ir = 8'h00;
    tick(1);
    expectOut("t5_irr_drop", SEL_IRR, 8'h00);
    tick(1);
    expectOut("t5_int_drop", SEL_INT, 8'h00);
    intaFall();
    expectOut("t5_num_spur", SEL_NUM, 8'h07);
    expectOut("t5_int_ack", SEL_INT, 8'h01);
    intaRise();
    intaFall();
    expectOut("t5_isr_spur", SEL_ISR, 8'h00);
    expectOut("t5_int_end", SEL_INT, 8'h00);
    intaRise();

    // Reset in the middle of an acknowledge
    applyStimulus(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(2);
    intaFall();
    expectOut("t6_num_pre", SEL_NUM, 8'h00);
    reset = 1'b1;
    ir    = 8'h00;
    tick(1);
    expectOut("t6_rst_int", SEL_INT, 8'h00);
    expectOut("t6_rst_isr", SEL_ISR, 8'h00);
    expectOut("t6_rst_irr", SEL_IRR, 8'h00);
    reset = 1'b0;
    intaRise();
    ir = 8'h01;
    tick(2);
    expectOut("t6_int", SEL_INT, 8'h01);
    intaFall();
    expectOut("t6_isr_first", SEL_ISR, 8'h00);
    intaRise();
    intaFall();
    expectOut("t6_isr", SEL_ISR, 8'h01);
    expectOut("t6_irr", SEL_IRR, 8'h00);
    intaRise();
    tick(2);

    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
